// File: rtl/pwm_setpoint_conditioner.sv
// pwm_setpoint_conditioner: turns a signed DSP sample or a manual bus code into the
// unsigned config word for the PWM DAC. It adds an offset with saturation and loads the
// output only on PWM metacycle sync pulses, so the modulation pattern never tears.
// Optional feature macro: PWM_COND_SLEW_EN limits the output step per metacycle to slew_i.
module pwm_setpoint_conditioner #(
    parameter int unsigned     DW         = 14,
    parameter int unsigned     CCW        = 24,
    parameter logic [CCW-1:0]  RESET_CODE = '0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [DW-1:0]  dat_i,
    input  logic           dat_vld_i,
    input  logic           mode_i,
    input  logic [CCW-1:0] man_i,
    input  logic           man_we_i,
    input  logic [CCW:0]   offset_i,
    input  logic           freeze_i,
    input  logic [CCW-1:0] slew_i,
    input  logic           pwm_s_i,
    output logic [CCW-1:0] cfg_o,
    output logic           upd_o,
    output logic           sat_hi_o,
    output logic           sat_lo_o
);

    logic [DW-1:0]  u;
    logic [CCW-1:0] a_next;
    logic [CCW-1:0] s1_a;
    logic           s1_vld;
    logic [CCW+1:0] sum;
    logic [CCW-1:0] tgt_next;
    logic           hi_next;
    logic           lo_next;
    logic [CCW-1:0] target;
    logic [CCW-1:0] cfg_next;

    // Offset-binary conversion, left-justified into the config width.
    always_comb begin
        u      = {~dat_i[DW-1], dat_i[DW-2:0]};
        a_next = CCW'(u) << (CCW - DW);
    end

    // Stage-2 offset add and clamp to the unsigned config range.
    always_comb begin
        sum      = {2'b00, s1_a} + {offset_i[CCW], offset_i};
        tgt_next = sum[CCW-1:0];
        hi_next  = 1'b0;
        lo_next  = 1'b0;
        if (sum[CCW+1]) begin
            tgt_next = '0;
            lo_next  = 1'b1;
        end else if (sum[CCW]) begin
            tgt_next = '1;
            hi_next  = 1'b1;
        end
    end

`ifdef PWM_COND_SLEW_EN
    logic [CCW:0] diff;
    logic [CCW:0] mag;

    // Step toward target by at most slew_i; a short remaining distance lands exactly.
    always_comb begin
        diff     = {1'b0, target} - {1'b0, cfg_o};
        mag      = diff[CCW] ? (~diff + 1'b1) : diff;
        cfg_next = target;
        if ((slew_i != '0) && (mag > {1'b0, slew_i})) begin
            cfg_next = diff[CCW] ? (cfg_o - slew_i) : (cfg_o + slew_i);
        end
    end
`else
    logic unused_slew;
    assign unused_slew = ^slew_i;

    // Without slew limiting the output jumps straight to target.
    always_comb begin
        cfg_next = target;
    end
`endif

    // Sample pipeline and target register; manual mode flushes the pipeline.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_a     <= '0;
            s1_vld   <= 1'b0;
            target   <= RESET_CODE;
            sat_hi_o <= 1'b0;
            sat_lo_o <= 1'b0;
        end else if (mode_i) begin
            s1_vld <= 1'b0;
            if (man_we_i) begin
                target   <= man_i;
                sat_hi_o <= 1'b0;
                sat_lo_o <= 1'b0;
            end
        end else begin
            s1_vld <= dat_vld_i;
            if (dat_vld_i) begin
                s1_a <= a_next;
            end
            if (s1_vld) begin
                target   <= tgt_next;
                sat_hi_o <= hi_next;
                sat_lo_o <= lo_next;
            end
        end
    end

    // Output register, loaded only on an unfrozen sync pulse from the pre-edge target.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cfg_o <= RESET_CODE;
            upd_o <= 1'b0;
        end else if (pwm_s_i && !freeze_i) begin
            cfg_o <= cfg_next;
            upd_o <= (cfg_next != cfg_o);
        end else begin
            upd_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_setpoint_conditioner.sv
// Scoreboard bench for pwm_setpoint_conditioner: expected output words are queued when a
// sync pulse is driven and popped when the DUT pulses upd_o.
module tb_pwm_setpoint_conditioner;

    localparam int DW  = 14;
    localparam int CCW = 24;

    logic           clk = 1'b0;
    logic           rstn;
    logic [DW-1:0]  dat_i;
    logic           dat_vld_i;
    logic           mode_i;
    logic [CCW-1:0] man_i;
    logic           man_we_i;
    logic [CCW:0]   offset_i;
    logic           freeze_i;
    logic [CCW-1:0] slew_i;
    logic           pwm_s_i;
    logic [CCW-1:0] cfg_o;
    logic           upd_o;
    logic           sat_hi_o;
    logic           sat_lo_o;

    int             n_vec  = 0;
    int             n_err  = 0;
    int             n_push = 0;
    int             n_upd  = 0;
    logic [CCW-1:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_setpoint_conditioner #(
        .DW        (DW),
        .CCW       (CCW),
        .RESET_CODE(24'h000000)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .dat_i    (dat_i),
        .dat_vld_i(dat_vld_i),
        .mode_i   (mode_i),
        .man_i    (man_i),
        .man_we_i (man_we_i),
        .offset_i (offset_i),
        .freeze_i (freeze_i),
        .slew_i   (slew_i),
        .pwm_s_i  (pwm_s_i),
        .cfg_o    (cfg_o),
        .upd_o    (upd_o),
        .sat_hi_o (sat_hi_o),
        .sat_lo_o (sat_lo_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid sample, then enough idle cycles for it to reach target.
    task automatic sample(input logic [DW-1:0] d);
        dat_i     = d;
        dat_vld_i = 1'b1;
        tick();
        dat_vld_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse();
        pwm_s_i = 1'b1;
        tick();
        pwm_s_i = 1'b0;
        tick();
    endtask

    task automatic expect_cfg(input logic [CCW-1:0] v);
        exp_q.push_back(v);
        n_push++;
    endtask

    task automatic man_write(input logic [CCW-1:0] v);
        man_i    = v;
        man_we_i = 1'b1;
        tick();
        man_we_i = 1'b0;
        tick();
    endtask

    // Every upd_o pulse must match the oldest queued expected word.
    always @(negedge clk) begin
        if (rstn && upd_o) begin
            n_upd++;
            if (exp_q.size() == 0) begin
                check("upd_unexpected", 32'(cfg_o), 32'hFFFF_FFFF);
            end else begin
                check("cfg_on_upd", 32'(cfg_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rstn = 1'b0; dat_i = '0; dat_vld_i = 1'b0; mode_i = 1'b0; man_i = '0;
        man_we_i = 1'b0; offset_i = '0; freeze_i = 1'b0; slew_i = '0; pwm_s_i = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("rst_cfg", 32'(cfg_o), 32'h0);
        check("rst_upd", 32'(upd_o), 32'h0);
        check("rst_sat", {30'h0, sat_hi_o, sat_lo_o}, 32'h0);

        // Midscale sample
        sample(14'h0000);
        expect_cfg(24'h800000);
        pulse();
        check("mid_cfg", 32'(cfg_o), 32'h800000);

        // Most negative sample maps to 0 without clipping
        sample(14'h2000);
        expect_cfg(24'h000000);
        pulse();
        check("neg_cfg", 32'(cfg_o), 32'h0);
        check("neg_sat", {30'h0, sat_hi_o, sat_lo_o}, 32'h0);

        // Full-scale plus offset clips high
        offset_i = 25'h0000800;
        sample(14'h1FFF);
        expect_cfg(24'hFFFFFF);
        pulse();
        check("hi_cfg", 32'(cfg_o), 32'hFFFFFF);
        check("hi_sat", {30'h0, sat_hi_o, sat_lo_o}, 32'h2);

        // In-range sample with a small positive offset
        offset_i = 25'h0000123;
        sample(14'h0100);
        expect_cfg(24'h840123);
        pulse();
        check("ofs_cfg", 32'(cfg_o), 32'h840123);
        check("ofs_sat", {30'h0, sat_hi_o, sat_lo_o}, 32'h0);

        // Negative offset below zero clips low
        offset_i = 25'h1FFF000;
        sample(14'h2000);
        expect_cfg(24'h000000);
        pulse();
        check("lo_cfg", 32'(cfg_o), 32'h0);
        check("lo_sat", {30'h0, sat_hi_o, sat_lo_o}, 32'h1);
        offset_i = '0;

        // Manual write coincident with sync is deferred to the next sync
        mode_i   = 1'b1;
        man_i    = 24'h123456;
        man_we_i = 1'b1;
        pwm_s_i  = 1'b1;
        tick();
        man_we_i = 1'b0;
        pwm_s_i  = 1'b0;
        check("man_same_upd", 32'(upd_o), 32'h0);
        tick();
        check("man_same_cfg", 32'(cfg_o), 32'h0);
        check("man_sat_clr", {30'h0, sat_hi_o, sat_lo_o}, 32'h0);
        expect_cfg(24'h123456);
        pulse();
        check("man_cfg", 32'(cfg_o), 32'h123456);

        // Samples are ignored in manual mode
        sample(14'h0555);
        pulse();
        check("man_ign_cfg", 32'(cfg_o), 32'h123456);

        // Freeze holds the output across several syncs
        man_write(24'h00ABCD);
        freeze_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pwm_s_i = 1'b1;
            tick();
            pwm_s_i = 1'b0;
            check("frz_upd", 32'(upd_o), 32'h0);
            tick();
            check("frz_cfg", 32'(cfg_o), 32'h123456);
        end
        freeze_i = 1'b0;
        expect_cfg(24'h00ABCD);
        pulse();
        check("unfrz_cfg", 32'(cfg_o), 32'h00ABCD);

`ifdef PWM_COND_SLEW_EN
        // Slew-limited ramp up, then down
        man_write(24'h000000);
        expect_cfg(24'h000000);
        pulse();
        slew_i = 24'h000100;
        man_write(24'h000250);
        expect_cfg(24'h000100);
        expect_cfg(24'h000200);
        expect_cfg(24'h000250);
        for (int i = 0; i < 5; i++) pulse();
        check("slew_up_cfg", 32'(cfg_o), 32'h250);
        man_write(24'h000010);
        expect_cfg(24'h000150);
        expect_cfg(24'h000050);
        expect_cfg(24'h000010);
        for (int i = 0; i < 4; i++) pulse();
        check("slew_dn_cfg", 32'(cfg_o), 32'h10);
        slew_i = '0;
`endif

        // Reset between a sample and its sync discards the sample
        mode_i    = 1'b0;
        dat_i     = 14'h0000;
        dat_vld_i = 1'b1;
        tick();
        dat_vld_i = 1'b0;
        rstn      = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst2_cfg", 32'(cfg_o), 32'h0);
        tick();
        tick();
        pulse();
        check("rst2_lost_cfg", 32'(cfg_o), 32'h0);

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("upd_count", 32'(n_upd), 32'(n_push));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
